// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu arbiter slice: command codes, data width,
// arbiter state encoding and the quiet-NaN value returned on a watchdog abort.
package fpu_pkg;

    localparam int FPU_WIDTH = 32;

    localparam logic [3:0] FPU_CMD_ADD  = 4'h0;
    localparam logic [3:0] FPU_CMD_SUB  = 4'h1;
    localparam logic [3:0] FPU_CMD_MUL  = 4'h2;
    localparam logic [3:0] FPU_CMD_DIV  = 4'h3;
    localparam logic [3:0] FPU_CMD_SQRT = 4'h4;
    localparam logic [3:0] FPU_CMD_CMP  = 4'h5;
    localparam logic [3:0] FPU_CMD_I2F  = 4'h6;
    localparam logic [3:0] FPU_CMD_F2I  = 4'h7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic [FPU_WIDTH-1:0] FPU_QNAN = 32'h7FC00000;

endpackage

// File: rtl/fpu_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection. Scans upward from the
// requester after last_grant and wraps around; grant is one-hot, found says
// whether any requester was valid.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic             found
);

    // First pass covers indices above last_grant, second pass the wrapped part.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && valid[j] && (j > int'(last_grant))) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && valid[j] && (j <= int'(last_grant))) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares a single fpu between N_REQ requesters with round-robin
// arbitration. One operation is in flight at a time:
//   IDLE  -> grant, latch operands, pulse req_ready[owner]
//   ISSUE -> fpu_input_rdy held until fpu_input_ack
//   WAIT  -> wait for fpu_output_rdy, pulse fpu_output_ack
//   RESP  -> rsp_valid[owner] held until rsp_ack[owner]
// Handshakes: a requester holds req_valid and its operands until it sees its
// req_ready pulse; a response stays on rsp_valid/rsp_result until the owner's
// rsp_ack is sampled high; the fpu side is a level rdy / pulse ack pair.
// Optional watchdog: define FPU_ARB_TIMEOUT_EN to abort a stuck operation
// after TIMEOUT_CYCLES with a qNaN result and a sticky timeout flag.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [4*N_REQ-1:0]    req_command,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_result,
    input  logic [N_REQ-1:0]      rsp_ack,
    output logic [3:0]            fpu_command,
    output logic [31:0]           fpu_data_a,
    output logic [31:0]           fpu_data_b,
    output logic                  fpu_input_rdy,
    input  logic                  fpu_input_ack,
    input  logic                  fpu_output_rdy,
    output logic                  fpu_output_ack,
    input  logic [31:0]           fpu_result,
    output logic                  busy,
    output logic                  timeout,
    output logic [1:0]            arb_state
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_RESP  = RESP;

    logic [1:0]       state;
    logic [N_REQ-1:0] owner_oh;
    logic [IDX_W-1:0] owner_idx;
    logic [IDX_W-1:0] last_grant;

    logic [N_REQ-1:0] pick_grant;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [3:0]       pick_cmd;
    logic [31:0]      pick_a;
    logic [31:0]      pick_b;
    logic             wd_fire;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .found      (pick_found)
    );

    // Select the winning requester's operands and index from the one-hot grant.
    always_comb begin
        pick_idx = '0;
        pick_cmd = '0;
        pick_a   = '0;
        pick_b   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (pick_grant[j]) begin
                pick_idx = IDX_W'(j);
                pick_cmd = req_command[4*j +: 4];
                pick_a   = req_a[32*j +: 32];
                pick_b   = req_b[32*j +: 32];
            end
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // Fires on the last allowed ISSUE/WAIT cycle unless the fpu completes in it.
    assign wd_fire = ((state == ST_ISSUE && !(fpu_input_ack && fpu_output_rdy)) ||
                      (state == ST_WAIT  && !fpu_output_rdy)) &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter restarts for every operation; timeout flag is sticky.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                wd_cnt <= '0;
            end else if (state == ST_ISSUE || state == ST_WAIT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_fire = 1'b0;
    // Watchdog absent: the flag is constant low.
    assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // Arbitration FSM with registered handshake outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            owner_oh       <= '0;
            owner_idx      <= '0;
            last_grant     <= IDX_W'(N_REQ - 1);
            req_ready      <= '0;
            rsp_valid      <= '0;
            rsp_result     <= '0;
            fpu_command    <= '0;
            fpu_data_a     <= '0;
            fpu_data_b     <= '0;
            fpu_input_rdy  <= 1'b0;
            fpu_output_ack <= 1'b0;
        end else begin
            req_ready      <= '0;
            fpu_output_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        fpu_command   <= pick_cmd;
                        fpu_data_a    <= pick_a;
                        fpu_data_b    <= pick_b;
                        owner_oh      <= pick_grant;
                        owner_idx     <= pick_idx;
                        req_ready     <= pick_grant;
                        fpu_input_rdy <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (fpu_input_ack && fpu_output_rdy) begin
                        rsp_result     <= fpu_result;
                        fpu_output_ack <= 1'b1;
                        fpu_input_rdy  <= 1'b0;
                        rsp_valid      <= owner_oh;
                        state          <= ST_RESP;
                    end else if (wd_fire) begin
                        rsp_result     <= FPU_QNAN;
                        fpu_output_ack <= 1'b1;
                        fpu_input_rdy  <= 1'b0;
                        rsp_valid      <= owner_oh;
                        state          <= ST_RESP;
                    end else if (fpu_input_ack) begin
                        fpu_input_rdy <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fpu_output_rdy) begin
                        rsp_result     <= fpu_result;
                        fpu_output_ack <= 1'b1;
                        rsp_valid      <= owner_oh;
                        state          <= ST_RESP;
                    end else if (wd_fire) begin
                        rsp_result     <= FPU_QNAN;
                        fpu_output_ack <= 1'b1;
                        rsp_valid      <= owner_oh;
                        state          <= ST_RESP;
                    end
                end
                default: begin
                    // Only the owner's ack releases the response.
                    if ((rsp_ack & owner_oh) != '0) begin
                        rsp_valid  <= '0;
                        last_grant <= owner_idx;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign arb_state = state;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: stub fpu with configurable ack delay / latency,
// requester and ack drivers, a round-robin scoreboard and directed tests.
module tb_fpu_arbiter;
    import fpu_pkg::*;

    localparam int N   = 2;
    localparam int TMO = 64;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT ----------------
    logic [N-1:0]    req_valid;
    logic [4*N-1:0]  req_command;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]    req_ready, rsp_valid, rsp_ack;
    logic [31:0]     rsp_result;
    logic [3:0]      fpu_command;
    logic [31:0]     fpu_data_a, fpu_data_b, fpu_result;
    logic            fpu_input_rdy, fpu_input_ack, fpu_output_rdy, fpu_output_ack;
    logic            busy, timeout;
    logic [1:0]      arb_state;

    fpu_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_command(req_command), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_ack(rsp_ack),
        .fpu_command(fpu_command), .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b),
        .fpu_input_rdy(fpu_input_rdy), .fpu_input_ack(fpu_input_ack),
        .fpu_output_rdy(fpu_output_rdy), .fpu_output_ack(fpu_output_ack), .fpu_result(fpu_result),
        .busy(busy), .timeout(timeout), .arb_state(arb_state)
    );

    // ---------------- bookkeeping ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Stub fpu arithmetic: the one real-valued vector is tabulated, anything
    // else gets a deterministic scramble so results stay distinguishable.
    function automatic logic [31:0] stub_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c == FPU_CMD_ADD && a == 32'h3F800000 && b == 32'h3C23D70A) return 32'h3F8147AE;
        return (a ^ {b[15:0], b[31:16]}) + {28'd0, c};
    endfunction

    // Round-robin rule: first valid requester after `last`, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // ---------------- driver state ----------------
    op_t q0[$], q1[$];
    op_t pres_op [N];
    int  ack_wait = 0;
    bit  nack_pulse = 0;
    int  rsp_age = 0;
    int  stub_ack_dly = 0, stub_lat = 1;
    bit  stub_same = 0, stub_never = 0;
    int  stub_st = 0, stub_cnt = 0;
    logic [31:0] stub_res = '0;

    task automatic pack_req();
        req_command = {pres_op[1].cmd, pres_op[0].cmd};
        req_a       = {pres_op[1].a,   pres_op[0].a};
        req_b       = {pres_op[1].b,   pres_op[0].b};
    endtask

    task automatic drive_step();
        if (!reset) begin
            req_valid = '0; rsp_ack = '0; rsp_age = 0;
            stub_st = 0; stub_cnt = 0;
            fpu_input_ack = 1'b0; fpu_output_rdy = 1'b0; fpu_result = '0;
            pack_req();
            return;
        end
        // requesters: drop after req_ready, then reload from their queues
        for (int i = 0; i < N; i++) if (req_ready[i]) req_valid[i] = 1'b0;
        if (!req_valid[0] && q0.size() > 0) begin pres_op[0] = q0.pop_front(); req_valid[0] = 1'b1; end
        if (!req_valid[1] && q1.size() > 0) begin pres_op[1] = q1.pop_front(); req_valid[1] = 1'b1; end
        pack_req();
        // response acks
        if (rsp_valid != '0) begin
            if (rsp_age >= ack_wait) rsp_ack = rsp_valid;
            else if (nack_pulse && rsp_age == 3) rsp_ack = ~rsp_valid;
            else rsp_ack = '0;
            rsp_age++;
        end else begin
            rsp_ack = '0;
            rsp_age = 0;
        end
        // stub fpu
        case (stub_st)
            0: begin
                fpu_input_ack = 1'b0;
                if (fpu_input_rdy) begin
                    if (stub_cnt >= stub_ack_dly) begin
                        fpu_input_ack = 1'b1;
                        stub_res = stub_fn(fpu_command, fpu_data_a, fpu_data_b);
                        stub_cnt = 0;
                        if (stub_same) begin
                            fpu_output_rdy = 1'b1; fpu_result = stub_res; stub_st = 2;
                        end else stub_st = 1;
                    end else stub_cnt++;
                end
            end
            1: begin
                fpu_input_ack = 1'b0;
                stub_cnt++;
                if (fpu_output_ack) begin
                    stub_st = 0; stub_cnt = 0;
                end else if (!stub_never && stub_cnt >= stub_lat) begin
                    fpu_output_rdy = 1'b1; fpu_result = stub_res; stub_st = 2;
                end
            end
            default: begin
                fpu_input_ack = 1'b0;
                if (fpu_output_ack) begin
                    fpu_output_rdy = 1'b0; stub_st = 0; stub_cnt = 0;
                end
            end
        endcase
    endtask

    initial begin
        req_valid = '0; rsp_ack = '0;
        fpu_input_ack = 1'b0; fpu_output_rdy = 1'b0; fpu_result = '0;
        for (int i = 0; i < N; i++) pres_op[i] = '0;
        pack_req();
        forever begin
            @(negedge clock);
            #1;
            drive_step();
        end
    end

    // ---------------- scoreboard / compare process ----------------
    logic [33:0] exp_q[$];          // {owner one-hot, result}
    int          grant_log[$];
    int          m_last = N - 1;
    op_t         cur_op = '0;
    logic [N-1:0] pv = '0;
    bit          prev_busy = 0, prev_oack = 0, mon_en = 0;
    int          oack_cnt = 0, rsp_run = 0, last_run = 0;
    logic [31:0] last_rsp_result = '0;

    always @(negedge clock) begin
        if (reset && mon_en) begin
            chk("rsp_onehot", $onehot0(rsp_valid), 1'b1);
            // response consumed at the preceding edge?
            if (pv != '0 && (rsp_ack & pv) != '0) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (pv != '0) begin
                chk("rsp_hold", rsp_valid, pv);
            end
            if (rsp_valid != '0) begin
                last_rsp_result = rsp_result;
                rsp_run++;
                if (exp_q.size() == 0) chk("rsp_stale", rsp_valid, '0);
                else begin
                    chk("rsp_owner", rsp_valid, exp_q[0][33:32]);
                    chk("rsp_result", rsp_result, exp_q[0][31:0]);
                end
            end else if (pv != '0) begin
                last_run = rsp_run;
                rsp_run = 0;
            end
            // new grant
            if (req_ready != '0) begin
                int e;
                chk("grant_from_idle", prev_busy, 1'b0);
                e = rr_pick(req_valid, m_last);
                chk("grant_owner", req_ready, (e < 0) ? 2'b00 : 2'(1 << e));
                if (e >= 0) begin
                    m_last = e;
                    grant_log.push_back(e);
                    cur_op = pres_op[e];
                    exp_q.push_back({2'(1 << e),
                        stub_never ? FPU_QNAN : stub_fn(cur_op.cmd, cur_op.a, cur_op.b)});
                end
            end
            if (fpu_input_rdy) chk("fpu_operands", {fpu_command, fpu_data_a, fpu_data_b}, cur_op);
            if (fpu_output_ack) begin
                chk("oack_pulse", prev_oack, 1'b0);
                oack_cnt++;
            end
            prev_busy = busy;
            prev_oack = fpu_output_ack;
            pv        = rsp_valid;
        end
    end

    // ---------------- test helpers ----------------
    function automatic logic [127:0] all_outs();
        return {req_ready, rsp_valid, rsp_result, fpu_command, fpu_data_a, fpu_data_b,
                fpu_input_rdy, fpu_output_ack, busy, timeout, arb_state};
    endfunction

    task automatic clear_model();
        q0.delete(); q1.delete(); exp_q.delete();
        m_last = N - 1; pv = '0; prev_busy = 0; prev_oack = 0; rsp_run = 0;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clock);
        #3 reset = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #3 reset = 1'b0;
        clear_model();
        release_reset();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        bit done;
        n = 0; done = 0;
        while (!done && n < budget) begin
            @(negedge clock);
            #2;
            done = (q0.size() == 0 && q1.size() == 0 && req_valid == '0 &&
                    !busy && rsp_valid == '0 && exp_q.size() == 0);
            n++;
        end
        chk(name, done, 1'b1);
    endtask

    task automatic check_log(input string name, input int cnt, input logic [15:0] exp);
        logic [15:0] got;
        got = '0;
        for (int i = 0; i < grant_log.size() && i < 8; i++) got = {got[13:0], 2'(grant_log[i])};
        chk({name, "_len"}, grant_log.size(), cnt);
        chk(name, got, exp);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bit seen;
        int n;

        // reset state
        @(negedge clock); #2;
        chk("reset_outputs", all_outs(), '0);
        release_reset();
        mon_en = 1;

        // T1: single ADD from requester 0
        stub_ack_dly = 1; stub_lat = 2;
        q0.push_back('{FPU_CMD_ADD, 32'h3F800000, 32'h3C23D70A});
        seen = 0; n = 0;
        while (!seen && n < 50) begin
            @(negedge clock); #2;
            seen = rsp_valid[0];
            n++;
        end
        chk("t1_rsp_seen", seen, 1'b1);
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_result", rsp_result, 32'h3F8147AE);
        wait_drain("t1_drain", 100);
        check_log("t1_grants", 1, 16'h0000);

        // T2: both requesters continuously valid -> 0,1,0,1
        do_reset();
        grant_log.delete();
        stub_ack_dly = 0; stub_lat = 1;
        q0.push_back('{FPU_CMD_MUL, 32'h40000000, 32'h40400000});
        q0.push_back('{FPU_CMD_SUB, 32'h12345678, 32'h9ABCDEF0});
        q1.push_back('{FPU_CMD_DIV, 32'hC0A00000, 32'h3F000000});
        q1.push_back('{FPU_CMD_SQRT, 32'h41100000, 32'h00000000});
        wait_drain("t2_drain", 200);
        check_log("t2_grants", 4, 16'b00_01_00_01);

        // T3: input_ack and output_rdy together
        grant_log.delete();
        stub_same = 1; oack_cnt = 0;
        q1.push_back('{FPU_CMD_CMP, 32'hDEADBEEF, 32'h0BADF00D});
        wait_drain("t3_drain", 100);
        chk("t3_oack_cycles", oack_cnt, 1);
        check_log("t3_grants", 1, 16'b01);
        stub_same = 0;

        // T4: slow owner ack, non-owner ack pulse, other requester waiting
        grant_log.delete();
        ack_wait = 10; nack_pulse = 1; stub_lat = 3;
        q0.push_back('{FPU_CMD_I2F, 32'h0000002A, 32'h11111111});
        q1.push_back('{FPU_CMD_F2I, 32'h42280000, 32'h22222222});
        wait_drain("t4_drain", 200);
        chk("t4_rsp_cycles", last_run, 11);
        check_log("t4_grants", 2, 16'b00_01);
        ack_wait = 0; nack_pulse = 0;

        // T5: reset while waiting on the fpu
        stub_lat = 20;
        q1.push_back('{FPU_CMD_ADD, 32'h55555555, 32'hAAAAAAAA});
        seen = 0; n = 0;
        while (!seen && n < 30) begin
            @(negedge clock); #2;
            seen = (arb_state == WAIT);
            n++;
        end
        chk("t5_reached_wait", seen, 1'b1);
        #1 reset = 1'b0;
        #1 chk("t5_async_reset", all_outs(), '0);
        clear_model();
        grant_log.delete();
        release_reset();
        stub_lat = 1;
        q0.push_back('{FPU_CMD_SUB, 32'h01020304, 32'h05060708});
        q1.push_back('{FPU_CMD_MUL, 32'h3F800000, 32'h3F800000});
        wait_drain("t5_drain", 200);
        check_log("t5_grants", 2, 16'b00_01);

`ifdef FPU_ARB_TIMEOUT_EN
        // T6: fpu never responds -> qNaN and sticky timeout
        stub_never = 1;
        q0.push_back('{FPU_CMD_DIV, 32'h3F800000, 32'h00000000});
        wait_drain("t6_drain_timeout", 300);
        chk("t6_qnan", last_rsp_result, 32'h7FC00000);
        chk("t6_timeout_set", timeout, 1'b1);
        stub_never = 0;
        q1.push_back('{FPU_CMD_ADD, 32'h3F800000, 32'h3C23D70A});
        wait_drain("t6_drain_normal", 100);
        chk("t6_normal_result", last_rsp_result, 32'h3F8147AE);
        chk("t6_timeout_sticky", timeout, 1'b1);
`else
        chk("timeout_tied_low", timeout, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
